// File: rtl/coeff_loader.sv
// Streams NUM_COEFFS words from a valid/ready source into a filter coefficient port; one write per accepted word,
// one cycle after the transfer. Ready is high only in LOAD with clk_enable, and the source stalls until then.
module coeff_loader #(
  parameter int NUM_COEFFS  = 64,
  parameter int ADDR_WIDTH  = 6,
  parameter int COEFF_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_enable,
  input  logic                          i_start,
  input  logic                          i_coeff_valid,
  input  logic signed [COEFF_WIDTH-1:0] i_coeff_data,
  output logic                          o_coeff_ready,
  output logic                          o_write_enable,
  output logic        [ADDR_WIDTH-1:0]  o_write_address,
  output logic signed [COEFF_WIDTH-1:0] o_coeffs_out,
  output logic                          o_write_done,
  output logic                          o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_COEFFS - 1);

  state_t                          state_q, state_d;
  logic        [ADDR_WIDTH-1:0]    cnt_q, cnt_d;
  logic        [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic signed [COEFF_WIDTH-1:0]   data_q, data_d;
  logic                            we_q, we_d;
  logic                            done_q, done_d;
  logic                            transfer;

  assign o_coeff_ready = (state_q == ST_LOAD) && clk_enable;
  assign transfer      = i_coeff_valid && o_coeff_ready;

  // Strobes default low every cycle so a disabled edge clears them instead of replaying them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    if (clk_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end
        end
        ST_LOAD: begin
          if (i_start) begin
            cnt_d = '0;
          end else if (transfer) begin
            addr_d = cnt_q;
            data_d = i_coeff_data;
            we_d   = 1'b1;
            if (cnt_q == LAST_ADDR) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign o_write_enable  = we_q;
  assign o_write_address = addr_q;
  assign o_coeffs_out    = data_q;
  assign o_write_done    = done_q;
  assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: driver pushes expected writes into a queue, a negedge monitor pops and compares.
module tb_coeff_loader;
  localparam int N  = 64;
  localparam int AW = 6;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clk_enable;
  logic                 i_start;
  logic                 i_coeff_valid;
  logic signed [CW-1:0] i_coeff_data;
  logic                 o_coeff_ready;
  logic                 o_write_enable;
  logic [AW-1:0]        o_write_address;
  logic [CW-1:0]        o_coeffs_out;
  logic                 o_write_done;
  logic                 o_busy;

  coeff_loader #(.NUM_COEFFS(N), .ADDR_WIDTH(AW), .COEFF_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .clk_enable      (clk_enable),
    .i_start         (i_start),
    .i_coeff_valid   (i_coeff_valid),
    .i_coeff_data    (i_coeff_data),
    .o_coeff_ready   (o_coeff_ready),
    .o_write_enable  (o_write_enable),
    .o_write_address (o_write_address),
    .o_coeffs_out    (o_coeffs_out),
    .o_write_done    (o_write_done),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [CW-1:0] d;
  } wr_t;

  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  logic prev_last = 1'b0;
  int   model_addr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest expected write; done must follow the last address.
  always @(negedge clk) begin
    wr_t e;
    if (o_write_done === 1'b1) begin
      check("done_after_last_write", {31'd0, prev_last}, 32'd1);
      done_cnt++;
    end else if (prev_last) begin
      check("done_missing", {31'd0, o_write_done}, 32'd1);
    end
    prev_last = 1'b0;
    if (o_write_enable === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", o_write_address, o_coeffs_out);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {26'd0, o_write_address}, {26'd0, e.a});
        check("wr_data", {16'd0, o_coeffs_out}, {16'd0, e.d});
        prev_last = (e.a == AW'(N - 1));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string name, input logic exp_busy);
    @(negedge clk);
    check(name, {31'd0, o_busy}, {31'd0, exp_busy});
    cyc();
  endtask

  task automatic start_load();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    model_addr = 0;
  endtask

  task automatic xfer(input logic [CW-1:0] d);
    wr_t e;
    i_coeff_valid = 1'b1;
    i_coeff_data  = d;
    @(negedge clk);
    check("ready_on_xfer", {31'd0, o_coeff_ready}, 32'd1);
    e.a = AW'(model_addr);
    e.d = d;
    exp_q.push_back(e);
    model_addr = (model_addr == N - 1) ? 0 : model_addr + 1;
    cyc();
    i_coeff_valid = 1'b0;
  endtask

  task automatic counts(input string name, input int w0, input int d0, input int exp_w, input int exp_d);
    check({name, "_writes"}, wr_cnt - w0, exp_w);
    check({name, "_dones"}, done_cnt - d0, exp_d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int w0, d0;
    rst = 1'b1; clk_enable = 1'b1; i_start = 1'b0; i_coeff_valid = 1'b0; i_coeff_data = '0;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_we",    {31'd0, o_write_enable}, 32'd0);
    check("rst_addr",  {26'd0, o_write_address}, 32'd0);
    check("rst_data",  {16'd0, o_coeffs_out}, 32'd0);
    check("rst_done",  {31'd0, o_write_done}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_ready", {31'd0, o_coeff_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    idle_check("idle_busy", 1'b0);

    // Back-to-back full load of 1..64
    w0 = wr_cnt; d0 = done_cnt;
    start_load();
    for (int i = 0; i < N; i++) xfer(CW'(i + 1));
    idle_check("busy_in_done", 1'b1);
    idle_check("busy_after_done", 1'b0);
    counts("b2b", w0, d0, 64, 1);

    // Valid toggling 1/0, then a start pulse during DONE that must be ignored
    w0 = wr_cnt; d0 = done_cnt;
    start_load();
    for (int i = 0; i < N; i++) begin
      xfer(CW'(16'h0100 + i));
      if (i < N - 1) cyc();
    end
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    idle_check("start_in_done_ignored", 1'b0);
    idle_check("still_idle", 1'b0);
    counts("gaps", w0, d0, 64, 1);

    // clk_enable low for 5 cycles after the write to address 20
    w0 = wr_cnt; d0 = done_cnt;
    start_load();
    for (int i = 0; i <= 20; i++) xfer(CW'(16'h2000 + i));
    cyc();
    clk_enable = 1'b0;
    i_coeff_valid = 1'b1;
    i_coeff_data = 16'hBAD0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_no_write", {31'd0, o_write_enable}, 32'd0);
      check("stall_no_ready", {31'd0, o_coeff_ready}, 32'd0);
      check("stall_busy", {31'd0, o_busy}, 32'd1);
      cyc();
    end
    clk_enable = 1'b1;
    i_coeff_valid = 1'b0;
    for (int i = 21; i < N; i++) xfer(CW'(16'h2000 + i));
    idle_check("stall_busy_in_done", 1'b1);
    idle_check("stall_busy_after", 1'b0);
    counts("stall", w0, d0, 64, 1);

    // Restart after 10 writes; the same-cycle word must be discarded
    w0 = wr_cnt; d0 = done_cnt;
    start_load();
    for (int i = 0; i < 10; i++) xfer(CW'(16'h3000 + i));
    i_start = 1'b1;
    i_coeff_valid = 1'b1;
    i_coeff_data = 16'hDEAD;
    cyc();
    i_start = 1'b0;
    i_coeff_valid = 1'b0;
    model_addr = 0;
    for (int i = 0; i < N; i++) xfer(CW'(16'h3100 + i));
    idle_check("restart_busy_in_done", 1'b1);
    idle_check("restart_busy_after", 1'b0);
    counts("restart", w0, d0, 74, 1);

    // Reset for 6 cycles after 30 writes, with start held high to check reset priority
    w0 = wr_cnt; d0 = done_cnt;
    start_load();
    for (int i = 0; i < 30; i++) xfer(CW'(16'h4000 + i));
    rst = 1'b1;
    i_start = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rstmid_we",    {31'd0, o_write_enable}, 32'd0);
      check("rstmid_addr",  {26'd0, o_write_address}, 32'd0);
      check("rstmid_data",  {16'd0, o_coeffs_out}, 32'd0);
      check("rstmid_done",  {31'd0, o_write_done}, 32'd0);
      check("rstmid_busy",  {31'd0, o_busy}, 32'd0);
      check("rstmid_ready", {31'd0, o_coeff_ready}, 32'd0);
      cyc();
    end
    rst = 1'b0;
    i_start = 1'b0;
    check("rstmid_queue_drained", exp_q.size(), 32'd0);
    idle_check("rstmid_idle", 1'b0);
    counts("rstmid", w0, d0, 30, 0);

    // Clean reload from address 0 with the signed extremes first
    w0 = wr_cnt; d0 = done_cnt;
    start_load();
    xfer(16'h8000);
    @(negedge clk);
    check("neg_extreme", {16'd0, o_coeffs_out}, 32'h8000);
    check("neg_sign", {31'd0, $signed(o_coeffs_out) < 0}, 32'd1);
    cyc();
    xfer(16'h7FFF);
    @(negedge clk);
    check("pos_extreme", {16'd0, o_coeffs_out}, 32'h7FFF);
    check("pos_sign", {31'd0, $signed(o_coeffs_out) > 0}, 32'd1);
    cyc();
    for (int i = 2; i < N; i++) xfer(CW'(16'h5000 + i));
    idle_check("reload_busy_in_done", 1'b1);
    idle_check("reload_busy_after", 1'b0);
    counts("reload", w0, d0, 64, 1);

    repeat (2) cyc();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
